// File: rtl/arb_pkg.sv
// Shared widths, FSM encoding and a clog2 helper for the arbiter writer lane.
package arb_pkg;

    localparam int DATA_W  = 8;
    localparam int COUNT_W = 16;
    localparam int STALL_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        STALL = 2'd2
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/arb_writer_fifo.sv
// Synchronous byte FIFO; pointers carry one extra bit and wrap naturally,
// full/empty are judged from the level register alone.
module arb_writer_fifo
    import arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] head,
    output logic [AW:0]       level,
    output logic [AW:0]       level_next
);

    localparam logic [AW:0] ONE_L = (AW + 1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + ONE_L;
            2'b01:   level_next = level - ONE_L;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE_L;
            if (pop)  rd_ptr <= rd_ptr + ONE_L;
            level <= level_next;
        end
    end

    // Storage is not reset: the top masks the head whenever the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/arb_writer.sv
// Requester lane endpoint: buffers producer bytes and offers them to the shared
// arbiter with req/busy, counting accepted bytes and flagging long stalls.
module arb_writer
    import arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STALL_CYCLES = 16,
    localparam int AW          = clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [DATA_W-1:0]  i_wr_data,
    input  logic               i_wr_valid,
    output logic               o_wr_ready,
    output logic               o_req,
    output logic [DATA_W-1:0]  o_data,
    input  logic               i_busy,
    output logic [AW:0]        o_level,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_stall
);

    // Producer side: a byte moves when i_wr_valid && o_wr_ready at a rising edge.
    // Arbiter side:  a byte moves when o_req && !i_busy at a rising edge; until
    // then o_req and o_data hold their values.

    localparam logic [AW:0]      DEPTH_L = DEPTH[AW:0];
    localparam logic [STALL_W-1:0] STALL_L = STALL_W'(STALL_CYCLES);

    arb_state_e         state;
    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_inc;
    logic               wr_ready_q;
    logic               stall_q;
    logic [COUNT_W-1:0] count_q;
    logic               push;
    logic               pop;
    logic [DATA_W-1:0]  head;
    logic [AW:0]        level;
    logic [AW:0]        level_next;

    assign push = i_wr_valid && wr_ready_q;
    assign pop  = o_req && !i_busy;

    arb_writer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .push       (push),
        .pop        (pop),
        .wr_data    (i_wr_data),
        .head       (head),
        .level      (level),
        .level_next (level_next)
    );

    assign stall_inc = (stall_cnt == '1) ? stall_cnt : stall_cnt + STALL_W'(1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ready_q <= 1'b0;
            count_q    <= '0;
        end else begin
            wr_ready_q <= (level_next < DEPTH_L);
            if (pop) count_q <= count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            stall_cnt <= '0;
            stall_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    stall_q   <= 1'b0;
                    if (level_next != '0) state <= REQ;
                end
                REQ, STALL: begin
                    if (pop) begin
                        stall_cnt <= '0;
                        stall_q   <= 1'b0;
                        state     <= (level_next != '0) ? REQ : IDLE;
                    end else if (i_busy) begin
                        // Counter saturates; STALL is entered on the edge the count hits the limit.
                        stall_cnt <= stall_inc;
                        if (stall_inc >= STALL_L) begin
                            state   <= STALL;
                            stall_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    stall_cnt <= '0;
                    stall_q   <= 1'b0;
                end
            endcase
        end
    end

    // o_req follows the asynchronously cleared level so reset drops it at once.
    assign o_req      = (level != '0);
    assign o_data     = o_req ? head : '0;
    assign o_level    = level;
    assign o_count    = count_q;
    assign o_stall    = stall_q;
    assign o_wr_ready = wr_ready_q;

endmodule

// File: tb/tb_arb_writer.sv
// Randomised and directed bench for arb_writer against a queue-based model.
module tb_arb_writer;

    localparam int DEPTH        = 4;
    localparam int STALL_CYCLES = 16;

    logic        i_clk;
    logic        i_reset_n;
    logic [7:0]  i_wr_data;
    logic        i_wr_valid;
    logic        o_wr_ready;
    logic        o_req;
    logic [7:0]  o_data;
    logic        i_busy;
    logic [2:0]  o_level;
    logic [15:0] o_count;
    logic        o_stall;

    int tests;
    int fails;

    logic [7:0] exp_q[$];
    int         m_count;
    int         m_blk;
    logic       m_ready;

    arb_writer #(
        .DEPTH        (DEPTH),
        .STALL_CYCLES (STALL_CYCLES)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_wr_data  (i_wr_data),
        .i_wr_valid (i_wr_valid),
        .o_wr_ready (o_wr_ready),
        .o_req      (o_req),
        .o_data     (o_data),
        .i_busy     (i_busy),
        .o_level    (o_level),
        .o_count    (o_count),
        .o_stall    (o_stall)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_count = 0;
        m_blk   = 0;
        m_ready = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp_data;
        exp_data = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        chk({tag, ".req"},   32'(o_req),      32'(exp_q.size() != 0));
        chk({tag, ".data"},  32'(o_data),     32'(exp_data));
        chk({tag, ".level"}, 32'(o_level),    32'(exp_q.size()));
        chk({tag, ".count"}, 32'(o_count),    32'(m_count % 65536));
        chk({tag, ".ready"}, 32'(o_wr_ready), 32'(m_ready));
        chk({tag, ".stall"}, 32'(o_stall),    32'(m_blk >= STALL_CYCLES));
    endtask

    // One clock: drive inputs, advance the model by the handshake rules, check after the edge.
    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic b);
        logic do_push;
        logic do_pop;
        logic blocked;
        i_wr_valid = v;
        i_wr_data  = d;
        i_busy     = b;
        do_push = v && m_ready;
        do_pop  = (exp_q.size() != 0) && !b;
        blocked = (exp_q.size() != 0) && b;
        if (do_pop) begin
            void'(exp_q.pop_front());
            m_count++;
            m_blk = 0;
        end else if (blocked) begin
            m_blk = (m_blk >= 255) ? 255 : m_blk + 1;
        end else begin
            m_blk = 0;
        end
        if (do_push) exp_q.push_back(d);
        m_ready = (exp_q.size() < DEPTH);
        @(posedge i_clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int burst;
        logic bv;
        logic bb;
        tests      = 0;
        fails      = 0;
        i_reset_n  = 1'b0;
        i_wr_valid = 1'b0;
        i_wr_data  = 8'h00;
        i_busy     = 1'b1;
        model_reset();

        // Reset, idle with busy high
        #3;
        check_all("reset");
        #19;
        i_reset_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(o_wr_ready), 32'd0);
        step("idle0", 1'b0, 8'h00, 1'b1);
        step("idle1", 1'b0, 8'h00, 1'b1);

        // Single byte
        step("a5_push", 1'b1, 8'hA5, 1'b0);
        step("a5_pop",  1'b0, 8'h00, 1'b0);

        // Fill, ignored fifth push, ordered drain
        for (int i = 1; i <= 5; i++) step("fill", 1'b1, 8'(i), 1'b1);
        for (int i = 0; i < 5; i++)  step("drain", 1'b0, 8'h00, 1'b0);

        // Long stall with one queued byte
        step("stall_push", 1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 20; i++) step("stall_hold", 1'b0, 8'h00, 1'b1);
        step("stall_pop", 1'b0, 8'h00, 1'b0);
        step("stall_idle", 1'b0, 8'h00, 1'b0);

        // Streaming at level 2 across pointer wrap
        step("stream_pre", 1'b1, 8'h10, 1'b1);
        step("stream_pre", 1'b1, 8'h11, 1'b1);
        for (int i = 0; i < 10; i++) step("stream", 1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 3; i++)  step("stream_drain", 1'b0, 8'h00, 1'b0);

        // Random traffic with occasional long busy bursts
        burst = 0;
        for (int i = 0; i < 400; i++) begin
            if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(10, 24);
            bv = 1'($urandom_range(0, 1));
            if (burst > 0) begin
                bb = 1'b1;
                burst--;
            end else begin
                bb = ($urandom_range(0, 3) == 0);
            end
            step("rand", bv, 8'($urandom_range(0, 255)), bb);
        end
        for (int i = 0; i < 5; i++) step("rand_drain", 1'b0, 8'h00, 1'b0);

        // Reset in the middle of a transfer at level 3
        for (int i = 0; i < 3; i++) step("mid_fill", 1'b1, 8'(8'hC0 + i), 1'b1);
        step("mid_hold", 1'b0, 8'h00, 1'b1);
        #2;
        i_reset_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        @(posedge i_clk);
        #1;
        check_all("mid_reset_held");
        #3;
        i_reset_n = 1'b1;
        i_busy    = 1'b0;
        #1;
        step("post_reset0", 1'b0, 8'h00, 1'b0);
        step("post_reset1", 1'b1, 8'h77, 1'b0);
        step("post_reset2", 1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
